led_stat: RTL and testbench

LED_STAT -- requirements
Module: led_stat

---
 rtl/led_stat.sv | 124 ++++++++++++
 tb/tb_led_stat.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_stat.sv
// led_stat: statistics counters and LED display bank for a small CPU core.
// Counts run cycles, jumps, conditional branches and taken branches, all
// saturating, and shows any of them (or the PC / address switches) one
// LED_W-wide page at a time on a registered LED bank. A heartbeat divider
// drives led_run; led_sat latches once any counter has pinned at all-ones.
// CNT_W/LED_W must be 1, 2 or 4 and ADDR_W must not exceed CNT_W.
module led_stat #(
  parameter int CNT_W  = 32,
  parameter int LED_W  = 16,
  parameter int ADDR_W = 12,
  parameter int HB_W   = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_en,
  input  logic [2:0]        sel,
  input  logic [1:0]        page,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [CNT_W-1:0]  pc_in,
  input  logic              halted,
  input  logic              ev_jmp,
  input  logic              ev_cond,
  input  logic              ev_taken,
  input  logic              clr,
  output logic [LED_W-1:0]  leds,
  output logic              led_run,
  output logic              led_sat
);

  localparam int RATIO = CNT_W / LED_W;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] jmp_q, jmp_d;
  logic [CNT_W-1:0] cnd_q, cnd_d;
  logic [CNT_W-1:0] tkn_q, tkn_d;
  logic             sat_q, sat_d;
  logic [HB_W-1:0]  hb_q, hb_d;
  logic             led_run_q, led_run_d;
  logic [LED_W-1:0] leds_q, leds_d;

  logic [CNT_W-1:0] disp_val;
  logic [LED_W-1:0] disp_slice;
  int               page_idx;

  // Saturating increment: a counter that has reached all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != ALL_ONES)) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // Pick the display source, then the page-sized slice of it.
  always_comb begin
    disp_val = ALL_ONES;
    case (sel)
      3'b000:  disp_val = CNT_W'(in_addr);
      3'b001:  disp_val = pc_in;
      3'b010:  disp_val = cyc_q;
      3'b011:  disp_val = jmp_q;
      3'b100:  disp_val = tkn_q;
      3'b101:  disp_val = cnd_q;
      3'b110:  disp_val = cnd_q - tkn_q;
      default: disp_val = ALL_ONES;
    endcase
    page_idx   = int'(page) % RATIO;
    disp_slice = disp_val[LED_W-1:0];
    for (int i = 0; i < RATIO; i++) begin
      if (page_idx == i) begin
        disp_slice = disp_val[i*LED_W +: LED_W];
      end
    end
  end

  // Next-state for counters, sticky saturation flag, heartbeat and LEDs.
  always_comb begin
    cyc_d = sat_inc(cyc_q, !halted);
    jmp_d = sat_inc(jmp_q, ev_jmp);
    cnd_d = sat_inc(cnd_q, ev_cond);
    tkn_d = sat_inc(tkn_q, ev_cond && ev_taken);
    sat_d = sat_q || (cyc_q == ALL_ONES) || (jmp_q == ALL_ONES) ||
            (cnd_q == ALL_ONES) || (tkn_q == ALL_ONES);
    if (clr) begin
      cyc_d = '0;
      jmp_d = '0;
      cnd_d = '0;
      tkn_d = '0;
      sat_d = 1'b0;
    end
    hb_d      = hb_q + HB_W'(1);
    led_run_d = halted ? 1'b1 : hb_d[HB_W-1];
    leds_d    = disp_en ? disp_slice : leds_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q     <= '0;
      jmp_q     <= '0;
      cnd_q     <= '0;
      tkn_q     <= '0;
      sat_q     <= 1'b0;
      hb_q      <= '0;
      led_run_q <= 1'b0;
      leds_q    <= '0;
    end else begin
      cyc_q     <= cyc_d;
      jmp_q     <= jmp_d;
      cnd_q     <= cnd_d;
      tkn_q     <= tkn_d;
      sat_q     <= sat_d;
      hb_q      <= hb_d;
      led_run_q <= led_run_d;
      leds_q    <= leds_d;
    end
  end

  assign leds    = leds_q;
  assign led_run = led_run_q;
  assign led_sat = sat_q;

endmodule

// File: tb/tb_led_stat.sv
// tb_led_stat: drives a narrow (8-bit counters, 4-bit LEDs) and a wide
// (32-bit counters, 16-bit LEDs) led_stat from the same stimulus and checks
// both against an unbounded-count reference model plus directed constants.
module tb_led_stat;

  logic        clk;
  logic        reset;
  logic        disp_en;
  logic [2:0]  sel;
  logic [1:0]  page;
  logic [11:0] in_addr;
  logic [31:0] pc_in;
  logic        halted;
  logic        ev_jmp;
  logic        ev_cond;
  logic        ev_taken;
  logic        clr;

  logic [15:0] leds_w;
  logic        led_run_w;
  logic        led_sat_w;
  logic [3:0]  leds_n;
  logic        led_run_n;
  logic        led_sat_n;

  int errors = 0;
  int checks = 0;

  // Reference model: raw event counts since the last clear/reset; the
  // saturated register value for a given width is min(raw, 2^w - 1).
  longint m_cyc, m_jmp, m_cnd, m_tkn, m_hb;
  logic [15:0] e_leds_w;
  logic [3:0]  e_leds_n;
  logic        e_run_w, e_run_n, e_sat_w, e_sat_n;

  led_stat #(.CNT_W(32), .LED_W(16), .ADDR_W(12), .HB_W(6)) dut_w (
    .clk(clk), .reset(reset), .disp_en(disp_en), .sel(sel), .page(page),
    .in_addr(in_addr), .pc_in(pc_in), .halted(halted), .ev_jmp(ev_jmp),
    .ev_cond(ev_cond), .ev_taken(ev_taken), .clr(clr),
    .leds(leds_w), .led_run(led_run_w), .led_sat(led_sat_w)
  );

  led_stat #(.CNT_W(8), .LED_W(4), .ADDR_W(8), .HB_W(4)) dut_n (
    .clk(clk), .reset(reset), .disp_en(disp_en), .sel(sel), .page(page),
    .in_addr(in_addr[7:0]), .pc_in(pc_in[7:0]), .halted(halted),
    .ev_jmp(ev_jmp), .ev_cond(ev_cond), .ev_taken(ev_taken), .clr(clr),
    .leds(leds_n), .led_run(led_run_n), .led_sat(led_sat_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint mask(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint cap(input longint x, input int w);
    return (x > mask(w)) ? mask(w) : x;
  endfunction

  function automatic longint sel_val(input int w, input int aw);
    case (sel)
      3'd0:    return longint'(in_addr) & mask(aw);
      3'd1:    return longint'(pc_in) & mask(w);
      3'd2:    return cap(m_cyc, w);
      3'd3:    return cap(m_jmp, w);
      3'd4:    return cap(m_tkn, w);
      3'd5:    return cap(m_cnd, w);
      3'd6:    return cap(m_cnd, w) - cap(m_tkn, w);
      default: return mask(w);
    endcase
  endfunction

  function automatic longint slice_of(input int w, input int lw, input int aw);
    int p;
    p = int'(page) % (w / lw);
    return (sel_val(w, aw) >> (lw * p)) & mask(lw);
  endfunction

  function automatic logic any_full(input int w);
    return (cap(m_cyc, w) == mask(w)) || (cap(m_jmp, w) == mask(w)) ||
           (cap(m_cnd, w) == mask(w)) || (cap(m_tkn, w) == mask(w));
  endfunction

  // One clock edge: model next state from current inputs, then step.
  task automatic tick();
    logic [15:0] nl_w;
    logic [3:0]  nl_n;
    logic        ns_w, ns_n, nr_w, nr_n;
    longint      nc, nj, nd, nt, nh;
    if (!reset) begin
      nl_w = '0; nl_n = '0; ns_w = 0; ns_n = 0; nr_w = 0; nr_n = 0;
      nc = 0; nj = 0; nd = 0; nt = 0; nh = 0;
    end else begin
      nl_w = disp_en ? 16'(slice_of(32, 16, 12)) : e_leds_w;
      nl_n = disp_en ? 4'(slice_of(8, 4, 8)) : e_leds_n;
      ns_w = clr ? 1'b0 : (e_sat_w || any_full(32));
      ns_n = clr ? 1'b0 : (e_sat_n || any_full(8));
      nc = clr ? 0 : m_cyc + (halted ? 0 : 1);
      nj = clr ? 0 : m_jmp + (ev_jmp ? 1 : 0);
      nd = clr ? 0 : m_cnd + (ev_cond ? 1 : 0);
      nt = clr ? 0 : m_tkn + ((ev_cond && ev_taken) ? 1 : 0);
      nh = m_hb + 1;
      nr_w = halted ? 1'b1 : 1'((nh >> 5) & 1);
      nr_n = halted ? 1'b1 : 1'((nh >> 3) & 1);
    end
    @(posedge clk);
    #1;
    e_leds_w = nl_w; e_leds_n = nl_n; e_sat_w = ns_w; e_sat_n = ns_n;
    e_run_w = nr_w; e_run_n = nr_n;
    m_cyc = nc; m_jmp = nj; m_cnd = nd; m_tkn = nt; m_hb = nh;
  endtask

  task automatic quiet_inputs();
    disp_en = 1'b1; sel = 3'd0; page = 2'd0; in_addr = '0; pc_in = '0;
    halted = 1'b0; ev_jmp = 1'b0; ev_cond = 1'b0; ev_taken = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; disp_en = 1'b1; clr = 1'b1; ev_jmp = 1'b1; ev_cond = 1'b1;
    ev_taken = 1'b1; halted = 1'b0; sel = 3'd7; page = 2'd0;
    tick(); tick();
    checks++; if (leds_w !== 16'h0) begin errors++; $display("[TB] FAIL reset_leds_w got %h want 0000", leds_w); end
    checks++; if (leds_n !== 4'h0) begin errors++; $display("[TB] FAIL reset_leds_n got %h want 0", leds_n); end
    checks++; if (led_run_w !== 1'b0) begin errors++; $display("[TB] FAIL reset_run_w got %b want 0", led_run_w); end
    checks++; if (led_run_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_run_n got %b want 0", led_run_n); end
    checks++; if (led_sat_w !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat_w got %b want 0", led_sat_w); end
    checks++; if (led_sat_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat_n got %b want 0", led_sat_n); end
    quiet_inputs();
  endtask

  task automatic test_cycle_count();
    quiet_inputs();
    reset = 1'b1; sel = 3'd2;
    repeat (5) tick();
    reset = 1'b0; tick();
    reset = 1'b1;
    repeat (10) tick();
    checks++; if (leds_w !== 16'h0009) begin errors++; $display("[TB] FAIL cyc10_leds_w got %h want 0009", leds_w); end
    checks++; if (leds_n !== 4'h9) begin errors++; $display("[TB] FAIL cyc10_leds_n got %h want 9", leds_n); end
    tick();
    checks++; if (leds_w !== 16'h000A) begin errors++; $display("[TB] FAIL cyc_value_w got %h want 000a", leds_w); end
  endtask

  task automatic test_branch_stats();
    quiet_inputs();
    halted = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ev_cond = 1'b1; ev_taken = (i < 3); tick();
      ev_cond = 1'b0; ev_taken = 1'b0; tick();
    end
    ev_taken = 1'b1; tick(); tick(); ev_taken = 1'b0;
    sel = 3'd4; tick();
    checks++; if (leds_w !== 16'd3) begin errors++; $display("[TB] FAIL tkn_w got %h want 0003", leds_w); end
    checks++; if (leds_n !== 4'd3) begin errors++; $display("[TB] FAIL tkn_n got %h want 3", leds_n); end
    sel = 3'd5; tick();
    checks++; if (leds_w !== 16'd5) begin errors++; $display("[TB] FAIL cnd_w got %h want 0005", leds_w); end
    sel = 3'd6; tick();
    checks++; if (leds_w !== 16'd2) begin errors++; $display("[TB] FAIL not_taken_w got %h want 0002", leds_w); end
    checks++; if (leds_n !== 4'd2) begin errors++; $display("[TB] FAIL not_taken_n got %h want 2", leds_n); end
    checks++; if (led_run_w !== 1'b1) begin errors++; $display("[TB] FAIL halted_run_w got %b want 1", led_run_w); end
  endtask

  task automatic test_paging();
    logic [15:0] want_w;
    logic [3:0]  want_n;
    quiet_inputs();
    pc_in = 32'hDEAD_BEEF; sel = 3'd1;
    for (int p = 0; p < 4; p++) begin
      page = 2'(p);
      want_w = (p % 2 == 1) ? 16'hDEAD : 16'hBEEF;
      want_n = (p % 2 == 1) ? 4'hE : 4'hF;
      tick();
      checks++; if (leds_w !== want_w) begin errors++; $display("[TB] FAIL page%0d_w got %h want %h", p, leds_w, want_w); end
      checks++; if (leds_n !== want_n) begin errors++; $display("[TB] FAIL page%0d_n got %h want %h", p, leds_n, want_n); end
    end
  endtask

  task automatic test_saturation();
    quiet_inputs();
    halted = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    ev_jmp = 1'b1; sel = 3'd3;
    repeat (260) tick();
    checks++; if (leds_n !== 4'hF) begin errors++; $display("[TB] FAIL jmp_sat_lo_n got %h want f", leds_n); end
    checks++; if (leds_w !== 16'h0103) begin errors++; $display("[TB] FAIL jmp_w got %h want 0103", leds_w); end
    page = 2'd1; ev_jmp = 1'b0; tick();
    checks++; if (leds_n !== 4'hF) begin errors++; $display("[TB] FAIL jmp_sat_hi_n got %h want f", leds_n); end
    checks++; if (leds_w !== 16'h0000) begin errors++; $display("[TB] FAIL jmp_hi_w got %h want 0000", leds_w); end
    checks++; if (led_sat_n !== 1'b1) begin errors++; $display("[TB] FAIL sat_set_n got %b want 1", led_sat_n); end
    checks++; if (led_sat_w !== 1'b0) begin errors++; $display("[TB] FAIL sat_clear_w got %b want 0", led_sat_w); end
    clr = 1'b1; ev_jmp = 1'b1; tick();
    clr = 1'b0; ev_jmp = 1'b0;
    checks++; if (led_sat_n !== 1'b0) begin errors++; $display("[TB] FAIL sat_cleared_n got %b want 0", led_sat_n); end
    page = 2'd0; tick();
    checks++; if (leds_n !== 4'h0) begin errors++; $display("[TB] FAIL jmp_cleared_n got %h want 0", leds_n); end
    checks++; if (leds_w !== 16'h0) begin errors++; $display("[TB] FAIL jmp_cleared_w got %h want 0000", leds_w); end
  endtask

  task automatic test_freeze();
    quiet_inputs();
    sel = 3'd0; in_addr = 12'hABC; tick();
    checks++; if (leds_w !== 16'h0ABC) begin errors++; $display("[TB] FAIL addr_w got %h want 0abc", leds_w); end
    checks++; if (leds_n !== 4'hC) begin errors++; $display("[TB] FAIL addr_n got %h want c", leds_n); end
    disp_en = 1'b0; in_addr = 12'h123;
    repeat (3) tick();
    checks++; if (leds_w !== 16'h0ABC) begin errors++; $display("[TB] FAIL frozen_w got %h want 0abc", leds_w); end
    checks++; if (leds_n !== 4'hC) begin errors++; $display("[TB] FAIL frozen_n got %h want c", leds_n); end
    disp_en = 1'b1; tick();
    checks++; if (leds_w !== 16'h0123) begin errors++; $display("[TB] FAIL thawed_w got %h want 0123", leds_w); end
    checks++; if (leds_n !== 4'h3) begin errors++; $display("[TB] FAIL thawed_n got %h want 3", leds_n); end
  endtask

  task automatic test_heartbeat();
    logic want_n, want_w;
    quiet_inputs();
    reset = 1'b0; tick(); reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      want_n = 1'((k >> 3) & 1);
      want_w = 1'((k >> 5) & 1);
      checks++; if (led_run_n !== want_n) begin errors++; $display("[TB] FAIL hb_n k=%0d got %b want %b", k, led_run_n, want_n); end
      checks++; if (led_run_w !== want_w) begin errors++; $display("[TB] FAIL hb_w k=%0d got %b want %b", k, led_run_w, want_w); end
    end
    halted = 1'b1; sel = 3'd2; tick();
    checks++; if (led_run_n !== 1'b1) begin errors++; $display("[TB] FAIL halt_run_n got %b want 1", led_run_n); end
    repeat (5) tick();
    checks++; if (leds_w !== 16'h0020) begin errors++; $display("[TB] FAIL halt_cyc_w got %h want 0020", leds_w); end
    checks++; if (led_run_w !== 1'b1) begin errors++; $display("[TB] FAIL halt_run_w got %b want 1", led_run_w); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      reset    = ($urandom_range(0, 99) != 0);
      clr      = ($urandom_range(0, 59) == 0);
      halted   = ($urandom_range(0, 7) == 0);
      disp_en  = ($urandom_range(0, 3) != 0);
      ev_jmp   = 1'($urandom);
      ev_cond  = 1'($urandom);
      ev_taken = 1'($urandom);
      sel      = 3'($urandom);
      page     = 2'($urandom);
      in_addr  = 12'($urandom);
      pc_in    = $urandom;
      tick();
      checks++; if (leds_w !== e_leds_w) begin errors++; $display("[TB] FAIL rnd%0d_leds_w got %h want %h", n, leds_w, e_leds_w); end
      checks++; if (leds_n !== e_leds_n) begin errors++; $display("[TB] FAIL rnd%0d_leds_n got %h want %h", n, leds_n, e_leds_n); end
      checks++; if (led_sat_w !== e_sat_w) begin errors++; $display("[TB] FAIL rnd%0d_sat_w got %b want %b", n, led_sat_w, e_sat_w); end
      checks++; if (led_sat_n !== e_sat_n) begin errors++; $display("[TB] FAIL rnd%0d_sat_n got %b want %b", n, led_sat_n, e_sat_n); end
      checks++; if (led_run_w !== e_run_w) begin errors++; $display("[TB] FAIL rnd%0d_run_w got %b want %b", n, led_run_w, e_run_w); end
      checks++; if (led_run_n !== e_run_n) begin errors++; $display("[TB] FAIL rnd%0d_run_n got %b want %b", n, led_run_n, e_run_n); end
    end
  endtask

  initial begin
    m_cyc = 0; m_jmp = 0; m_cnd = 0; m_tkn = 0; m_hb = 0;
    e_leds_w = '0; e_leds_n = '0;
    e_run_w = 0; e_run_n = 0; e_sat_w = 0; e_sat_n = 0;
    reset = 1'b0;
    quiet_inputs();
    test_reset();
    test_cycle_count();
    test_branch_stats();
    test_paging();
    test_saturation();
    test_freeze();
    test_heartbeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
